// File: rtl/mem_port_arb_pkg.sv
// Shared types and width helpers for the 2:1 memory port arbiter.
`ifndef REQ_NBITS
`define REQ_NBITS(n) (1 + 32 + 2 + (n))
`endif
`ifndef RESP_NBITS
`define RESP_NBITS(n) (1 + 2 + (n))
`endif

package mem_port_arb_pkg;

    typedef enum logic {
        SRC_IMEM = 1'b0,
        SRC_DMEM = 1'b1
    } src_id_t;

    localparam int unsigned MAX_INFLIGHT_DFLT = 4;
    localparam int unsigned PTR_W_DFLT        = $clog2(MAX_INFLIGHT_DFLT);
    localparam int unsigned CNT_W_DFLT        = PTR_W_DFLT + 1;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_port_arb_tag_fifo.sv
// In-order FIFO of request source ids; synchronous write, combinational head read.
module mem_port_arb_tag_fifo
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned p_depth = MAX_INFLIGHT_DFLT,
    localparam int unsigned PtrW   = ptr_width(p_depth),
    localparam int unsigned CntW   = PtrW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  src_id_t         din,
    output src_id_t         head,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    src_id_t         mem_q [p_depth];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CntW'(p_depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(p_depth); i++) begin
                mem_q[i] <= SRC_IMEM;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter_2to1.sv
// Shares one memory port between imem (port 0) and dmem (port 1), steering in-order responses.
// Define MEM_PORT_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority with port 1 winning.
`ifndef REQ_NBITS
`define REQ_NBITS(n) (1 + 32 + 2 + (n))
`endif
`ifndef RESP_NBITS
`define RESP_NBITS(n) (1 + 2 + (n))
`endif

module mem_port_arbiter_2to1
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned p_nbits        = 32,
    parameter int unsigned p_max_inflight = MAX_INFLIGHT_DFLT,
    localparam int unsigned ReqW          = `REQ_NBITS(p_nbits),
    localparam int unsigned RespW         = `RESP_NBITS(p_nbits),
    localparam int unsigned CntW          = ptr_width(p_max_inflight) + 1
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [ReqW-1:0]  req0_msg,
    output logic             resp0_val,
    input  logic             resp0_rdy,
    output logic [RespW-1:0] resp0_msg,

    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [ReqW-1:0]  req1_msg,
    output logic             resp1_val,
    input  logic             resp1_rdy,
    output logic [RespW-1:0] resp1_msg,

    output logic             memreq_val,
    input  logic             memreq_rdy,
    output logic [ReqW-1:0]  memreq_msg,
    input  logic             memresp_val,
    output logic             memresp_rdy,
    input  logic [RespW-1:0] memresp_msg
);

    logic            grant1;
    src_id_t         grant_src;
    logic            issue_ok;
    logic            push;
    logic            pop;
    src_id_t         head;
    logic            full;
    logic            empty;
    logic [CntW-1:0] count;
    logic            unused_full;

`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    src_id_t last_grant_q;

    // On a tie, port 1 wins unless it took the previous grant.
    assign grant1 = req1_val && (!req0_val || (last_grant_q == SRC_IMEM));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= SRC_DMEM;
        end else if (push) begin
            last_grant_q <= grant_src;
        end
    end
`else
    assign grant1 = req1_val;
`endif

    assign grant_src = grant1 ? SRC_DMEM : SRC_IMEM;

    // A pop in this cycle deliberately does not open a slot for this cycle's issue.
    assign issue_ok    = (count != CntW'(p_max_inflight));
    assign unused_full = full;

    assign memreq_val = reset && (req0_val || req1_val) && issue_ok;
    assign memreq_msg = grant1 ? req1_msg : req0_msg;
    assign req0_rdy   = reset && req0_val && !grant1 && issue_ok && memreq_rdy;
    assign req1_rdy   = reset && grant1 && issue_ok && memreq_rdy;
    assign push       = memreq_val && memreq_rdy;

    assign resp0_val   = reset && memresp_val && !empty && (head == SRC_IMEM);
    assign resp1_val   = reset && memresp_val && !empty && (head == SRC_DMEM);
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign memresp_rdy = reset && !empty && ((head == SRC_DMEM) ? resp1_rdy : resp0_rdy);
    assign pop         = memresp_val && memresp_rdy;

    mem_port_arb_tag_fifo #(
        .p_depth (p_max_inflight)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (grant_src),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_mem_port_arbiter_2to1.sv
// Directed bench for mem_port_arbiter_2to1 with a queue-based reference model checked every cycle.
`ifndef REQ_NBITS
`define REQ_NBITS(n) (1 + 32 + 2 + (n))
`endif
`ifndef RESP_NBITS
`define RESP_NBITS(n) (1 + 2 + (n))
`endif

module tb_mem_port_arbiter_2to1;

    localparam int unsigned NBITS  = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned REQ_W  = `REQ_NBITS(NBITS);
    localparam int unsigned RESP_W = `RESP_NBITS(NBITS);
`ifdef MEM_PORT_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_val, req0_rdy, resp0_val, resp0_rdy;
    logic              req1_val, req1_rdy, resp1_val, resp1_rdy;
    logic              memreq_val, memreq_rdy, memresp_val, memresp_rdy;
    logic [REQ_W-1:0]  req0_msg, req1_msg, memreq_msg;
    logic [RESP_W-1:0] resp0_msg, resp1_msg, memresp_msg;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_2to1 #(
        .p_nbits        (NBITS),
        .p_max_inflight (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_val    (req0_val),
        .req0_rdy    (req0_rdy),
        .req0_msg    (req0_msg),
        .resp0_val   (resp0_val),
        .resp0_rdy   (resp0_rdy),
        .resp0_msg   (resp0_msg),
        .req1_val    (req1_val),
        .req1_rdy    (req1_rdy),
        .req1_msg    (req1_msg),
        .resp1_val   (resp1_val),
        .resp1_rdy   (resp1_rdy),
        .resp1_msg   (resp1_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding request sources, oldest first.
    int mq[$];
    int last_src;
    bit m_push, m_pop;
    int m_grant;

    always @(negedge clk) begin
        int  grant;
        int  head;
        bit  ok, has, e_mv, e_r0, e_r1, e_mrdy;
        ok = (mq.size() < DEPTH);
        if (req0_val && req1_val) grant = RR ? ((last_src == 0) ? 1 : 0) : 1;
        else                      grant = req1_val ? 1 : 0;
        e_mv = reset && (req0_val || req1_val) && ok;
        check("m_memreq_val", memreq_val, e_mv);
        if (e_mv) check("m_memreq_msg", memreq_msg, (grant == 1) ? req1_msg : req0_msg);
        check("m_req0_rdy", req0_rdy, e_mv && memreq_rdy && grant == 0);
        check("m_req1_rdy", req1_rdy, e_mv && memreq_rdy && grant == 1);
        has    = (mq.size() > 0);
        head   = has ? mq[0] : 0;
        e_r0   = reset && memresp_val && has && head == 0;
        e_r1   = reset && memresp_val && has && head == 1;
        e_mrdy = reset && has && ((head == 1) ? resp1_rdy : resp0_rdy);
        check("m_resp0_val", resp0_val, e_r0);
        check("m_resp1_val", resp1_val, e_r1);
        check("m_memresp_rdy", memresp_rdy, e_mrdy);
        if (e_r0) check("m_resp0_msg", resp0_msg, memresp_msg);
        if (e_r1) check("m_resp1_msg", resp1_msg, memresp_msg);
        m_push  = e_mv && memreq_rdy;
        m_pop   = e_mrdy && memresp_val;
        m_grant = grant;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            last_src = 1;
            m_push   = 1'b0;
            m_pop    = 1'b0;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(m_grant);
                last_src = m_grant;
            end
            m_push = 1'b0;
            m_pop  = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {req0_val, req1_val, resp0_rdy, resp1_rdy, memreq_rdy, memresp_val} = '0;
        req0_msg = '0; req1_msg = '0; memresp_msg = '0;

        // Outputs stay quiet during reset even with traffic presented.
        req0_val = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b1; resp0_rdy = 1'b1;
        #2;
        check("rst_memreq_val", memreq_val, 1'b0);
        check("rst_req0_rdy", req0_rdy, 1'b0);
        check("rst_memresp_rdy", memresp_rdy, 1'b0);
        check("rst_resp0_val", resp0_val, 1'b0);
        req0_val = 1'b0; memresp_val = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Single request from port 0, addr 0x100.
        req0_msg = {1'b0, 32'h0000_0100, 2'd0, 32'h0};
        req0_val = 1'b1; resp1_rdy = 1'b1;
        #1;
        check("t1_memreq_val", memreq_val, 1'b1);
        check("t1_memreq_msg", memreq_msg, {1'b0, 32'h0000_0100, 2'd0, 32'h0});
        check("t1_req0_rdy", req0_rdy, 1'b1);
        step();
        req0_val = 1'b0; memresp_val = 1'b1; memresp_msg = {1'b0, 2'd0, 32'hCAFE_0100};
        #1;
        check("t1_resp0_val", resp0_val, 1'b1);
        check("t1_resp1_val", resp1_val, 1'b0);
        check("t1_resp0_msg", resp0_msg, {1'b0, 2'd0, 32'hCAFE_0100});
        step();
        memresp_val = 1'b0;
        #1 check("t1_empty_rdy", memresp_rdy, 1'b0);

        // Contention: both ports valid for 6 cycles, memory always ready.
        reset = 1'b0; #1 reset = 1'b1;
        @(posedge clk); #1;
        req0_val = 1'b1; req1_val = 1'b1; memresp_val = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_msg    = {1'b0, 32'h1000 + 32'(i), 2'd0, 32'(i)};
            req1_msg    = {1'b1, 32'h2000 + 32'(i), 2'd0, 32'(i)};
            memresp_msg = {1'b0, 2'd0, 32'hA000 + 32'(i)};
            #1;
            check("t2_req0_rdy", req0_rdy, RR ? (i % 2 == 0) : 1'b0);
            check("t2_req1_rdy", req1_rdy, RR ? (i % 2 == 1) : 1'b1);
            if (i > 0) check("t2_resp0_val", resp0_val, RR ? ((i - 1) % 2 == 0) : 1'b0);
            step();
        end
        req0_val = 1'b0; req1_val = 1'b0;
        step();
        memresp_val = 1'b0;

        // Fill all 4 slots with responses withheld; the 5th waits one cycle past the pop.
        req0_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_msg = {1'b0, 32'h3000 + 32'(i), 2'd0, 32'(i)};
            #1 check("t4_issue", memreq_val, 1'b1);
            step();
        end
        #1;
        check("t4_full_val", memreq_val, 1'b0);
        check("t4_full_rdy", req0_rdy, 1'b0);
        memresp_val = 1'b1;
        #1;
        check("t4_pop_same_cycle", memreq_val, 1'b0);
        check("t4_pop_rdy", memresp_rdy, 1'b1);
        step();
        memresp_val = 1'b0;
        #1;
        check("t4_next_val", memreq_val, 1'b1);
        check("t4_next_rdy", req0_rdy, 1'b1);
        step();
        req0_val = 1'b0; memresp_val = 1'b1;
        repeat (4) step();
        memresp_val = 1'b0;
        #1 check("t4_drained", memresp_rdy, 1'b0);

        // Response backpressure on port 1 holds the memory response.
        req1_val = 1'b1;
        step();
        req1_val = 1'b0; memresp_val = 1'b1; resp1_rdy = 1'b0; resp0_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_memresp_rdy", memresp_rdy, 1'b0);
            check("t5_resp0_val", resp0_val, 1'b0);
            check("t5_resp1_val", resp1_val, 1'b1);
            step();
        end
        resp1_rdy = 1'b1;
        #1 check("t5_release", memresp_rdy, 1'b1);
        step();
        memresp_val = 1'b0;

        // Asynchronous reset with 3 requests in flight.
        req0_val = 1'b1;
        repeat (3) step();
        memresp_val = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("t6_memreq_val", memreq_val, 1'b0);
        check("t6_req0_rdy", req0_rdy, 1'b0);
        check("t6_memresp_rdy", memresp_rdy, 1'b0);
        check("t6_resp0_val", resp0_val, 1'b0);
        memresp_val = 1'b0; req0_val = 1'b0;
        step();
        reset = 1'b1; req0_val = 1'b1;
        #1 check("t6_reissue", req0_rdy, 1'b1);
        step();
        req0_val = 1'b0; memresp_val = 1'b1;
        #1;
        check("t6_resp0_val_after", resp0_val, 1'b1);
        check("t6_resp1_val_after", resp1_val, 1'b0);
        step();
        memresp_val = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
